// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - sram-like instruction fetch bus between fetch stage and I-cache
interface pc_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch-stage PC register and single-outstanding I-cache fetch controller
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            pc_next,
  input  logic                   stall,
  input  logic                   flush,
  output logic [31:0]            pcF,
  output logic [31:0]            pc_4,
  output logic [31:0]            instF,
  output logic                   instF_valid,
  output logic                   adelF,
  pc_fetch_ctrl_if.master        ibus
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;

  logic        req_c;
  logic        valid_c;
  logic        adel_c;
  logic [31:0] inst_c;
  logic        misaligned;

  assign misaligned = |pc_q[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    req_c   = 1'b0;
    valid_c = 1'b0;
    adel_c  = 1'b0;
    inst_c  = 32'd0;

    case (state_q)
      S_REQ: begin
        // A misaligned PC never reaches the cache; it is presented as a faulting slot.
        if (misaligned) begin
          valid_c = 1'b1;
          adel_c  = 1'b1;
        end else begin
          req_c = 1'b1;
          if (ibus.inst_addr_ok) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ibus.inst_data_ok) begin
          valid_c = 1'b1;
          inst_c  = ibus.inst_rdata;
          buf_d   = ibus.inst_rdata;
          if (stall) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        valid_c = 1'b1;
        inst_c  = buf_q;
      end
      S_DISCARD: begin
        if (ibus.inst_data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (flush) begin
      pc_d    = pc_next;
      valid_c = 1'b0;
      // Any request the cache has accepted must have its response swallowed.
      case (state_q)
        S_WAIT:    state_d = ibus.inst_data_ok ? S_REQ : S_DISCARD;
        S_REQ:     state_d = (req_c && ibus.inst_addr_ok) ? S_DISCARD : S_REQ;
        S_DISCARD: state_d = ibus.inst_data_ok ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else if (valid_c && !stall) begin
      pc_d    = pc_next;
      state_d = S_REQ;
    end
  end

  // Outputs are gated by resetn so they clear as soon as reset asserts.
  assign ibus.inst_req  = resetn & req_c;
  assign ibus.inst_addr = pc_q;
  assign instF_valid    = resetn & valid_c;
  assign adelF          = resetn & adel_c;
  assign instF          = inst_c;
  assign pcF            = pc_q;
  assign pc_4           = pc_q + 32'd4;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed bench with a transaction-level reference model
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc_next = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        aok = 1'b0;
  logic        dok = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [31:0] pcF, pc_4, instF;
  logic        instF_valid, adelF;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl_if ibus();
  assign ibus.inst_addr_ok = aok;
  assign ibus.inst_data_ok = dok;
  assign ibus.inst_rdata   = rdata;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pc_next     (pc_next),
    .stall       (stall),
    .flush       (flush),
    .pcF         (pcF),
    .pc_4        (pc_4),
    .instF       (instF),
    .instF_valid (instF_valid),
    .adelF       (adelF),
    .ibus        (ibus)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: PC, whether a request is outstanding, whether its response is to
  // be dropped, and whether an instruction is already held for decode.
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_inst = 32'd0;
  bit          m_out = 0, m_drop = 0, m_have = 0;

  always @(negedge clk) begin
    bit          mis, idle, e_req, e_adel, arrive, raw, accepted;
    logic [31:0] e_inst;
    if (!resetn) begin
      m_pc = RST_PC; m_out = 0; m_drop = 0; m_have = 0; m_inst = 32'd0;
      chk1("m_rst_req", ibus.inst_req, 1'b0);
      chk1("m_rst_valid", instF_valid, 1'b0);
      chk1("m_rst_adel", adelF, 1'b0);
      chk32("m_rst_pc", pcF, RST_PC);
    end else begin
      mis      = (m_pc[1:0] != 2'b00);
      idle     = !m_out && !m_have;
      e_req    = idle && !mis;
      e_adel   = idle && mis;
      arrive   = m_out && dok;
      raw      = m_have || (arrive && !m_drop) || e_adel;
      e_inst   = m_have ? m_inst : ((arrive && !m_drop) ? rdata : 32'd0);
      accepted = e_req && aok;

      chk32("m_pcF", pcF, m_pc);
      chk32("m_pc_4", pc_4, m_pc + 32'd4);
      chk1("m_req", ibus.inst_req, e_req);
      chk32("m_addr", ibus.inst_addr, m_pc);
      chk1("m_valid", instF_valid, raw && !flush);
      chk1("m_adel", adelF, e_adel);
      if (raw && !flush) chk32("m_instF", instF, e_inst);

      if (flush) begin
        m_pc   = pc_next;
        m_have = 0;
        if (m_out && !dok) m_drop = 1;
        else if (m_out && dok) begin m_out = 0; m_drop = 0; end
        else if (accepted) begin m_out = 1; m_drop = 1; end
      end else begin
        if (arrive) begin
          if (!m_drop) begin m_have = 1; m_inst = rdata; end
          m_out  = 0;
          m_drop = 0;
        end
        if (accepted) m_out = 1;
        if (raw && !stall) begin m_pc = pc_next; m_have = 0; end
      end
    end
  end

  task automatic step(input bit a, input bit d, input logic [31:0] rd,
                      input bit st, input bit fl, input logic [31:0] pn);
    @(posedge clk); #1;
    aok = a; dok = d; rdata = rd; stall = st; flush = fl; pc_next = pn;
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req", ibus.inst_req, 1'b0);
    chk32("rst_pcF", pcF, 32'hbfc00000);
    @(negedge clk);
    resetn = 1'b1;

    // basic fetch: addr_ok then data_ok
    step(1, 0, 32'd0, 0, 0, 32'hbfc00004);
    chk1("c0_req", ibus.inst_req, 1'b1);
    chk32("c0_addr", ibus.inst_addr, 32'hbfc00000);
    chk1("c0_valid", instF_valid, 1'b0);
    step(0, 1, 32'h24010001, 0, 0, 32'hbfc00004);
    chk1("c1_valid", instF_valid, 1'b1);
    chk32("c1_instF", instF, 32'h24010001);
    chk32("c1_pcF", pcF, 32'hbfc00000);
    step(1, 0, 32'd0, 0, 0, 32'hbfc00008);
    chk32("adv_pcF", pcF, 32'hbfc00004);
    chk1("adv_req", ibus.inst_req, 1'b1);

    // stall for three cycles: instruction held four cycles
    step(0, 1, 32'h11111111, 1, 0, 32'hbfc00008);
    chk32("hold0_instF", instF, 32'h11111111);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 32'd0, 1, 0, 32'hbfc00008);
      chk1("hold_valid", instF_valid, 1'b1);
      chk32("hold_instF", instF, 32'h11111111);
      chk32("hold_pcF", pcF, 32'hbfc00004);
      chk1("hold_req", ibus.inst_req, 1'b0);
    end
    step(0, 0, 32'd0, 0, 0, 32'hbfc00008);
    chk32("hold3_instF", instF, 32'h11111111);
    chk1("hold3_valid", instF_valid, 1'b1);
    step(1, 0, 32'd0, 0, 0, 32'hbfc0000c);
    chk32("unstall_pcF", pcF, 32'hbfc00008);
    chk1("unstall_req", ibus.inst_req, 1'b1);

    // flush in WAIT, late response dropped
    step(0, 0, 32'd0, 0, 1, 32'hbfc00380);
    chk1("fw_valid", instF_valid, 1'b0);
    step(0, 0, 32'd0, 0, 0, 32'hbfc00384);
    chk1("disc_req", ibus.inst_req, 1'b0);
    chk32("disc_pcF", pcF, 32'hbfc00380);
    step(0, 1, 32'hdeadbeef, 0, 0, 32'hbfc00384);
    chk1("drop_valid", instF_valid, 1'b0);
    step(1, 0, 32'd0, 0, 0, 32'hbfc00384);
    chk1("refetch_req", ibus.inst_req, 1'b1);
    chk32("refetch_addr", ibus.inst_addr, 32'hbfc00380);

    // flush with stall during HOLD
    step(0, 1, 32'h22222222, 1, 0, 32'hbfc00384);
    step(0, 0, 32'd0, 1, 1, 32'hbfc00400);
    chk1("fh_valid", instF_valid, 1'b0);
    step(1, 0, 32'd0, 0, 0, 32'hbfc00404);
    chk32("fh_pcF", pcF, 32'hbfc00400);
    chk1("fh_req", ibus.inst_req, 1'b1);

    // advance onto a misaligned PC
    step(0, 1, 32'h33333333, 0, 0, 32'hbfc00002);
    step(1, 0, 32'd0, 1, 0, 32'hbfc00006);
    chk1("adel_adelF", adelF, 1'b1);
    chk32("adel_instF", instF, 32'd0);
    chk1("adel_valid", instF_valid, 1'b1);
    chk1("adel_req", ibus.inst_req, 1'b0);
    step(0, 0, 32'd0, 1, 1, 32'hbfc00380);
    chk1("adel_flush_valid", instF_valid, 1'b0);
    step(0, 1, 32'h55555555, 0, 0, 32'hbfc00384);
    chk1("rec_req", ibus.inst_req, 1'b1);
    chk32("rec_addr", ibus.inst_addr, 32'hbfc00380);
    chk1("stray_dok_valid", instF_valid, 1'b0);

    // flush in REQ coincident with addr_ok; pc_4 wrap
    step(1, 0, 32'd0, 0, 1, 32'hfffffffc);
    step(0, 1, 32'h66666666, 0, 0, 32'h00000000);
    chk1("fr_drop_valid", instF_valid, 1'b0);
    chk32("wrap_pcF", pcF, 32'hfffffffc);
    chk32("wrap_pc_4", pc_4, 32'h00000000);
    step(1, 0, 32'd0, 0, 0, 32'h00000000);
    chk32("wrap_addr", ibus.inst_addr, 32'hfffffffc);
    step(0, 1, 32'h77777777, 0, 0, 32'hbfc00010);
    chk32("wrap_instF", instF, 32'h77777777);

    // reset asserted mid-WAIT
    step(1, 0, 32'd0, 0, 0, 32'hbfc00014);
    @(posedge clk); #2;
    aok = 0; dok = 0;
    resetn = 1'b0;
    #1;
    chk1("async_req", ibus.inst_req, 1'b0);
    chk1("async_valid", instF_valid, 1'b0);
    chk1("async_adel", adelF, 1'b0);
    chk32("async_pcF", pcF, RST_PC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step(0, 1, 32'hdeadbeef, 0, 0, 32'hbfc00004);
    chk1("post_stale_valid", instF_valid, 1'b0);
    chk1("post_req", ibus.inst_req, 1'b1);
    chk32("post_addr", ibus.inst_addr, 32'hbfc00000);
    step(1, 0, 32'd0, 0, 0, 32'hbfc00004);
    step(0, 1, 32'h88888888, 0, 0, 32'hbfc00004);
    chk32("post_instF", instF, 32'h88888888);
    chk1("post_valid", instF_valid, 1'b1);
    step(0, 0, 32'd0, 0, 0, 32'hbfc00008);
    chk32("post_adv_pcF", pcF, 32'hbfc00004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Consumer end of the next-PC path. Holds the fetch-stage PC register and loads it from the selected pc_next.
- Issues instruction fetches to the I-cache over the sram-like req/addr_ok/data_ok handshake, with one request outstanding at most.
- Delivers instruction/PC pairs to decode, and handles pipeline stalls, flushes (exception/eret) and misaligned-PC exceptions.

Parameters:
- RESET_PC, 32'hbfc00000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pc_next  in  32  selected next PC (pc+4 / branch / jump / epc / exception entry).
- stall  in  1  decode cannot accept; hold current instruction.
- flush  in  1  exception or eret redirect; load pc_next immediately, kill in-flight fetch.
- pcF  out  32  current fetch PC.
- pc_4  out  32  pcF + 4, modulo 2^32.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address (= pcF).
- inst_addr_ok  in  1  cache accepted request.
- inst_data_ok  in  1  instruction data valid this cycle.
- inst_rdata  in  32  instruction data.
- instF  out  32  instruction to decode.
- instF_valid  out  1  instF/pcF valid this cycle.
- adelF  out  1  pcF misaligned (pcF[1:0] != 0); instF forced to 0.

Behaviour:
- Reset (async, resetn=0):
  - pcF=RESET_PC; state=REQ; instruction buffer=0.
  - inst_req=0, instF_valid=0, adelF=0 while resetn=0.
  - First request is issued in the first cycle after release.
- States: REQ, WAIT, HOLD, DISCARD.
- Advance event: instF_valid=1 && stall=0 && flush=0.
  - pcF<=pc_next; state<=REQ.
- REQ:
  - Aligned pcF: inst_req=1, inst_addr=pcF. addr_ok -> WAIT.
  - Misaligned pcF: inst_req=0, instF_valid=1, instF=0, adelF=1. The state stays REQ until advance or flush.
- WAIT:
  - inst_req=0.
  - On data_ok: instF_valid=1 and instF=inst_rdata (same-cycle bypass), and buffer<=inst_rdata.
    - stall=0: advance.
    - stall=1: -> HOLD.
- HOLD: instF_valid=1, instF=buffer; advance when stall=0.
- Flush (highest priority, overrides stall):
  - pcF<=pc_next; instF_valid forced 0 that cycle.
  - From WAIT without data_ok, or from REQ with addr_ok in the same cycle: -> DISCARD.
  - From WAIT with data_ok: -> REQ (the response is dropped).
  - From REQ without addr_ok, or from HOLD: -> REQ. inst_addr may change before addr_ok; the cache tolerates this.
- DISCARD:
  - inst_req=0, instF_valid=0.
  - On data_ok: drop the data, -> REQ.
  - Flush in DISCARD: update pcF, remain in DISCARD.
- Latency: minimum 2 cycles from request to instF_valid (addr_ok in cycle 0, data_ok in cycle 1). Throughput is 1 instruction per 2 cycles.
- Ordering: data_ok is never accepted in REQ; a data_ok there is a protocol error and is ignored.
- Delay slots: no internal flush on branch/jump. The instruction in F at the time a branch resolves is the delay slot, and pc_next already carries the target when that slot advances.
- pc_4 is purely combinational from pcF; 32'hfffffffc + 4 wraps to 0.

Test Plan:
- Reset release, cache returns addr_ok in cycle 0 and data_ok in cycle 1 with rdata 32'h24010001:
  - Cycle 0: inst_req=1, inst_addr=32'hbfc00000.
  - Cycle 1: instF_valid=1, instF=32'h24010001, pcF=bfc00000.
  - Next cycle: pcF=pc_next (bfc00004).
- data_ok arrives with stall=1 for 3 cycles:
  - HOLD presents the same instF for 4 cycles total and pcF is unchanged.
  - On stall=0, pcF loads pc_next and a new inst_req is issued next cycle.
- flush with pc_next=32'hbfc00380 while in WAIT; data_ok arrives 2 cycles later with 32'hdeadbeef:
  - instF_valid stays 0 and the data is dropped.
  - Next request has inst_addr=bfc00380.
- flush and stall=1 in the same cycle during HOLD:
  - Buffer discarded, pcF=pc_next, request issued next cycle.
- pc_next=32'hbfc00002 on advance:
  - adelF=1, instF=0, instF_valid=1, inst_req=0.
  - flush to bfc00380 recovers normal fetch.
- resetn low mid-WAIT:
  - Outputs clear asynchronously and pcF=RESET_PC.
  - After release, the first request is to bfc00000 and no stale instF_valid appears.
